// File: rtl/car_pkg.sv
// Shared definitions for the per-car sequencer: activity codes, state enum,
// default floor count and car_state field positions.
package car_pkg;

   localparam int N_FLOORS_DEF = 10;

   localparam logic [1:0] ACT_IDLE = 2'b00;
   localparam logic [1:0] ACT_UP   = 2'b01;
   localparam logic [1:0] ACT_DOWN = 2'b10;
   localparam logic [1:0] ACT_DOOR = 2'b11;

   // State codes double as the activity field of car_state.
   typedef enum logic [1:0] {
      ST_IDLE = ACT_IDLE,
      ST_UP   = ACT_UP,
      ST_DOWN = ACT_DOWN,
      ST_DOOR = ACT_DOOR
   } state_t;

   localparam int CS_FLOOR_MSB = 5;
   localparam int CS_FLOOR_LSB = 2;
   localparam int CS_ACT_MSB   = 1;
   localparam int CS_ACT_LSB   = 0;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/car_timer.sv
// Loadable down-counter with a done flag; times both floor travel and door dwell.
module car_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/car_sequencer.sv
// SCAN-policy motion sequencer for one elevator car with a pending-call bitmap.
// Optional CAR_SEQ_HOLD_EN adds door_hold, which keeps the door open while high.
module car_sequencer
   import car_pkg::*;
#(
   parameter int N_FLOORS      = N_FLOORS_DEF,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                call_valid,
   input  logic [3:0]          call_floor,
`ifdef CAR_SEQ_HOLD_EN
   input  logic                door_hold,
`endif
   output logic                call_ready,
   output logic                call_err,
   output logic [N_FLOORS-1:0] queue,
   output logic [5:0]          car_state,
   output logic                door_open
);

   localparam int TW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES)) + 1;
   // Timer is loaded with cycles-1 so done coincides with the last cycle of a segment.
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

   state_t              state_reg, state_next;
   logic [3:0]          floor_reg, floor_next;
   logic [N_FLOORS-1:0] queue_reg, queue_next;
   logic                last_up_reg, last_up_next;
   logic                call_ready_reg;
   logic                call_err_reg;

   logic                accept;
   logic                in_range;
   logic [3:0]          step_floor;
   logic [N_FLOORS-1:0] call_onehot, cur_mask, step_mask, clr_vec;
   logic [N_FLOORS-1:0] above_vec, below_vec, arrive_vec;
   logic                here_hit, arrive_hit, req_above, req_below, dir_up, dir_down;
   logic                timer_load, timer_done;
   logic [TW-1:0]       timer_value;

   assign accept   = call_valid & call_ready_reg;
   assign in_range = (32'(call_floor) < N_FLOORS);

   always_comb begin
      step_floor = floor_reg;
      if (state_reg == ST_UP && 32'(floor_reg) < N_FLOORS - 1) begin
         step_floor = floor_reg + 4'd1;
      end else if (state_reg == ST_DOWN && floor_reg != 4'd0) begin
         step_floor = floor_reg - 4'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_FLOORS; gi++) begin : g_floor
         assign call_onehot[gi] = accept && in_range && (call_floor == 4'(gi));
         assign cur_mask[gi]    = (floor_reg == 4'(gi));
         assign step_mask[gi]   = (step_floor == 4'(gi));
         assign above_vec[gi]   = queue_reg[gi] && (4'(gi) > floor_reg);
         assign below_vec[gi]   = queue_reg[gi] && (4'(gi) < floor_reg);
         assign arrive_vec[gi]  = step_mask[gi] && (queue_reg[gi] || call_onehot[gi]);
      end
   endgenerate

   assign here_hit   = |(queue_reg & cur_mask);
   assign arrive_hit = |arrive_vec;
   assign req_above  = |above_vec;
   assign req_below  = |below_vec;
   // With requests on both sides the last direction breaks the tie.
   assign dir_up     = req_above && (last_up_reg || !req_below);
   assign dir_down   = !dir_up && req_below;

   always_comb begin
      state_next   = state_reg;
      floor_next   = floor_reg;
      last_up_next = last_up_reg;
      timer_load   = 1'b0;
      timer_value  = TRAVEL_LOAD;
      clr_vec      = '0;
      case (state_reg)
         ST_IDLE: begin
            if (here_hit) begin
               clr_vec     = cur_mask;
               state_next  = ST_DOOR;
               timer_load  = 1'b1;
               timer_value = DOOR_LOAD;
            end else if (dir_up) begin
               state_next   = ST_UP;
               last_up_next = 1'b1;
               timer_load   = 1'b1;
            end else if (dir_down) begin
               state_next   = ST_DOWN;
               last_up_next = 1'b0;
               timer_load   = 1'b1;
            end
         end
         ST_UP, ST_DOWN: begin
            if (timer_done) begin
               floor_next = step_floor;
               timer_load = 1'b1;
               if (arrive_hit) begin
                  clr_vec     = step_mask;
                  state_next  = ST_DOOR;
                  timer_value = DOOR_LOAD;
               end
            end
         end
         ST_DOOR: begin
            // Calls for the floor being served are absorbed for the whole dwell.
            clr_vec = cur_mask;
`ifdef CAR_SEQ_HOLD_EN
            if (door_hold) begin
               timer_load  = 1'b1;
               timer_value = DOOR_LOAD;
            end else
`endif
            if (timer_done) begin
               if (dir_up) begin
                  state_next   = ST_UP;
                  last_up_next = 1'b1;
                  timer_load   = 1'b1;
               end else if (dir_down) begin
                  state_next   = ST_DOWN;
                  last_up_next = 1'b0;
                  timer_load   = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
      queue_next = (queue_reg | call_onehot) & ~clr_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         floor_reg      <= 4'd0;
         queue_reg      <= '0;
         last_up_reg    <= 1'b1;
         call_ready_reg <= 1'b0;
         call_err_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         floor_reg      <= floor_next;
         queue_reg      <= queue_next;
         last_up_reg    <= last_up_next;
         call_ready_reg <= 1'b1;
         call_err_reg   <= accept && !in_range;
      end
   end

   car_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   assign call_ready                           = call_ready_reg;
   assign call_err                             = call_err_reg;
   assign queue                                = queue_reg;
   assign car_state[CS_FLOOR_MSB:CS_FLOOR_LSB] = floor_reg;
   assign car_state[CS_ACT_MSB:CS_ACT_LSB]     = state_reg;
   assign door_open                            = (state_reg == ST_DOOR);

endmodule

// File: tb/tb_car_sequencer.sv
// Scoreboard bench for car_sequencer: a floor/queue reference model predicts
// every cycle's outputs; a monitor compares them at the falling edge.
module tb_car_sequencer;

   localparam int N  = 10;
   localparam int TR = 4;
   localparam int DR = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         call_valid = 1'b0;
   logic [3:0]   call_floor = 4'd0;
`ifdef CAR_SEQ_HOLD_EN
   logic         door_hold = 1'b0;
`endif
   logic         call_ready;
   logic         call_err;
   logic [N-1:0] queue;
   logic [5:0]   car_state;
   logic         door_open;

   car_sequencer #(
      .N_FLOORS      (N),
      .TRAVEL_CYCLES (TR),
      .DOOR_CYCLES   (DR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .call_valid (call_valid),
      .call_floor (call_floor),
`ifdef CAR_SEQ_HOLD_EN
      .door_hold  (door_hold),
`endif
      .call_ready (call_ready),
      .call_err   (call_err),
      .queue      (queue),
      .car_state  (car_state),
      .door_open  (door_open)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: mode 0 idle, 1 up, 2 down, 3 door; m_left counts the
   // cycles still to spend in the current travel or dwell segment.
   int           m_floor, m_mode, m_left;
   bit           m_last_up, m_ready, m_err;
   bit [N-1:0]   m_q;

   task automatic model_reset();
      m_floor = 0; m_mode = 0; m_left = 0;
      m_last_up = 1'b1; m_ready = 1'b0; m_err = 1'b0; m_q = '0;
   endtask

   task automatic pick_dir(input int above, input int below);
      if (above > 0 && (m_last_up || below == 0)) begin
         m_mode = 1; m_last_up = 1'b1; m_left = TR;
      end else if (below > 0) begin
         m_mode = 2; m_last_up = 1'b0; m_left = TR;
      end else begin
         m_mode = 0;
      end
   endtask

   task automatic model_step(input bit v, input int f, input bit hold);
      bit accept, have_call, absorb;
      int above, below;
      accept    = v && m_ready;
      have_call = accept && (f < N);
      m_err     = accept && (f >= N);
      absorb    = 1'b0;
      above = 0; below = 0;
      for (int i = 0; i < N; i++) begin
         if (m_q[i] && i > m_floor) above++;
         if (m_q[i] && i < m_floor) below++;
      end
      case (m_mode)
         0: begin
            if (m_q[m_floor]) begin
               m_q[m_floor] = 1'b0; m_mode = 3; m_left = DR;
               absorb = have_call && (f == m_floor);
            end else begin
               pick_dir(above, below);
            end
         end
         1, 2: begin
            m_left--;
            if (m_left == 0) begin
               m_floor = m_floor + ((m_mode == 1) ? 1 : -1);
               m_left  = TR;
               if (m_q[m_floor] || (have_call && f == m_floor)) begin
                  m_q[m_floor] = 1'b0; m_mode = 3; m_left = DR;
                  absorb = have_call && (f == m_floor);
               end
            end
         end
         default: begin
            absorb = have_call && (f == m_floor);
            m_left--;
            if (hold) m_left = DR;
            else if (m_left == 0) pick_dir(above, below);
         end
      endcase
      if (have_call && !absorb) m_q[f] = 1'b1;
      m_ready = 1'b1;
   endtask

   typedef struct {
      int           due;
      logic [5:0]   cs;
      logic         dop;
      logic [N-1:0] q;
      logic         err;
      logic         rdy;
   } exp_t;

   exp_t sb[$];

   task automatic tick(input bit v, input int f, input bit h);
      exp_t e;
`ifdef CAR_SEQ_HOLD_EN
      door_hold = h;
`endif
      call_valid = v;
      call_floor = 4'(f);
      if (v && m_ready)
         $display("cycle %0d: call floor %0d accepted (car at %0d, mode %0d)", cyc, f, m_floor, m_mode);
      model_step(v, f, h);
      e.due = cyc + 1;
      e.cs  = {4'(m_floor), 2'(m_mode)};
      e.dop = (m_mode == 3);
      e.q   = m_q;
      e.err = m_err;
      e.rdy = m_ready;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
               chk("sb_stale", 32'(e.due), 32'(cyc));
            end else begin
               chk("car_state", 32'(car_state), 32'(e.cs));
               chk("door_open", 32'(door_open), 32'(e.dop));
               chk("queue", 32'(queue), 32'(e.q));
               chk("call_err", 32'(call_err), 32'(e.err));
               chk("call_ready", 32'(call_ready), 32'(e.rdy));
               chk("floor_max", 32'(car_state[5:2] <= 4'(N - 1)), 32'd1);
            end
         end
      end
   end

   task automatic reset_mid();
      call_valid = 1'b0;
      @(negedge clk);
      #1;
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("rst_car_state", 32'(car_state), 32'd0);
      chk("rst_queue", 32'(queue), 32'd0);
      chk("rst_door_open", 32'(door_open), 32'd0);
      chk("rst_call_ready", 32'(call_ready), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_state", 32'(car_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      chk("rst_release_ready", 32'(call_ready), 32'd1);
   endtask

   initial begin
      int tries;
      bit h;
      model_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_car_state", 32'(car_state), 32'd0);
      chk("reset_queue", 32'(queue), 32'd0);
      chk("reset_door_open", 32'(door_open), 32'd0);
      chk("reset_call_err", 32'(call_err), 32'd0);
      chk("reset_call_ready", 32'(call_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      chk("ready_after_release", 32'(call_ready), 32'd1);

      // Directed: single up call, same-floor calls, out-of-range call.
      for (int c = 0; c <= 34; c++) begin
         case (c)
            1:  chk("up_queue_c1", 32'(queue), 32'h008);
            2:  chk("up_move_c2", 32'(car_state), 32'h01);
            6:  chk("up_floor1_c6", 32'(car_state[5:2]), 32'd1);
            10: chk("up_floor2_c10", 32'(car_state[5:2]), 32'd2);
            14: chk("up_door_c14", 32'(car_state), 32'({4'd3, 2'b11}));
            21: chk("up_door_c21", 32'(door_open), 32'd1);
            22: chk("up_idle_c22", 32'({queue, car_state}), 32'({10'd0, 4'd3, 2'b00}));
            24: chk("same_q_c24", 32'(queue), 32'h008);
            25: chk("same_door_c25", 32'({queue, car_state}), 32'({10'd0, 4'd3, 2'b11}));
            28: chk("err_pulse_c28", 32'({queue, call_err}), 32'd1);
            29: chk("err_clear_c29", 32'(call_err), 32'd0);
            default: ;
         endcase
         case (c)
            0, 16, 23: tick(1'b1, 3, 1'b0);
            27:        tick(1'b1, 12, 1'b0);
            default:   tick(1'b0, 0, 1'b0);
         endcase
      end

      // Randomized traffic, including out-of-range calls and a reset mid-move.
      for (int k = 0; k < 1500; k++) begin
         if (k == 600) begin
            tries = 0;
            while (!(m_mode == 1 || m_mode == 2) && tries < 200) begin
               tick(1'b1, $urandom_range(0, N - 1), 1'b0);
               tries++;
            end
            chk("reach_move", 32'(m_mode == 1 || m_mode == 2), 32'd1);
            reset_mid();
         end
         h = 1'b0;
`ifdef CAR_SEQ_HOLD_EN
         h = ($urandom_range(0, 7) == 0);
`endif
         tick($urandom_range(0, 3) == 0,
              ($urandom_range(0, 99) < 90) ? $urandom_range(0, N - 1) : $urandom_range(N, 15),
              h);
      end
      call_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
